// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM gate-pipeline sequencing controller.
package lstm_pkg;

    // Datapath latency in enabled (non-stalled) cycles.
    localparam int LSTM_STAGES = 4;

    // Tag width is sized for the largest supported HIDDEN (256 units).
    localparam int LSTM_UNIT_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_X = 3'd1,
        ISSUE  = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } lstm_state_t;

    // One in-flight hidden-unit computation as tracked by the shadow pipe.
    typedef struct packed {
        logic                   valid;
        logic [LSTM_UNIT_W-1:0] unit;
    } shadow_tag_t;

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// Control/issue/write-back bundle between the controller and its neighbours.
// The master side is the sequencing controller itself.
interface lstm_seq_ctrl_if #(
    parameter int HIDDEN  = 16,
    parameter int SEQ_MAX = 64
);
    localparam int UW = $clog2(HIDDEN);
    localparam int TW = $clog2(SEQ_MAX);
    localparam int LW = $clog2(SEQ_MAX + 1);

    logic          start;
    logic          abort;
    logic [LW-1:0] seq_len;
    logic          x_valid;
    logic          x_ack;
    logic          pipe_stall;
    logic          iss_valid;
    logic [UW-1:0] iss_unit;
    logic          iss_first;
    logic          rd_bank;
    logic          wb_valid;
    logic [UW-1:0] wb_unit;
    logic [TW-1:0] t_idx;
    logic          busy;
    logic          done;

    modport master (
        input  start, abort, seq_len, x_valid, pipe_stall,
        output x_ack, iss_valid, iss_unit, iss_first, rd_bank,
               wb_valid, wb_unit, t_idx, busy, done
    );

    modport slave (
        output start, abort, seq_len, x_valid, pipe_stall,
        input  x_ack, iss_valid, iss_unit, iss_first, rd_bank,
               wb_valid, wb_unit, t_idx, busy, done
    );

endinterface

// File: rtl/lstm_shadow_pipe.sv
// Tag shift register mirroring the datapath: entry 0 is stage 1, the last
// entry is the write-back stage. Shifts only when enabled; flush clears all.
module lstm_shadow_pipe
    import lstm_pkg::*;
#(
    parameter int STAGES = LSTM_STAGES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        flush_i,
    input  shadow_tag_t tag_i,
    output shadow_tag_t tag_o,
    output logic        pend_o
);

    shadow_tag_t [STAGES-1:0] pipe_q;
    shadow_tag_t [STAGES-1:0] pipe_d;

    // Next contents: flush wins, otherwise shift in the new tag when enabled.
    always_comb begin
        pipe_d = pipe_q;
        if (flush_i) begin
            pipe_d = '0;
        end else if (en_i) begin
            pipe_d = {pipe_q[STAGES-2:0], tag_i};
        end
    end

    // Tag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Work still upstream of the write-back stage.
    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            pend_o = pend_o | pipe_q[i].valid;
        end
    end

    assign tag_o = pipe_q[STAGES-1];

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Sequencing controller for the LSTM gate pipeline: walks seq_len timesteps,
// issues one hidden unit per cycle, tracks in-flight work in a shadow pipe,
// drives ping-pong write-back and holds off timestep t+1 until h_t is written.
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int HIDDEN  = 16,
    parameter int SEQ_MAX = 64,
    parameter int STAGES  = LSTM_STAGES
) (
    input  logic            clk,
    input  logic            rst_n,
    lstm_seq_ctrl_if.master bus
);

    localparam int UW = $clog2(HIDDEN);
    localparam int TW = $clog2(SEQ_MAX);
    localparam int LW = $clog2(SEQ_MAX + 1);

    lstm_state_t   state_q, state_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [TW-1:0] t_q, t_d;
    logic [LW-1:0] len_q, len_d;
    logic          bank_q, bank_d;

    logic          issue;
    logic          last_unit;
    logic          wb_fire;
    logic          pend;
    logic          drain_exit;
    logic [LW-1:0] len_clamp;
    shadow_tag_t   tag_in, tag_out;

    assign len_clamp  = (bus.seq_len > LW'(SEQ_MAX)) ? LW'(SEQ_MAX) : bus.seq_len;
    assign issue      = (state_q == ISSUE) && !bus.pipe_stall;
    assign last_unit  = (unit_q == UW'(HIDDEN - 1));
    assign wb_fire    = tag_out.valid && !bus.pipe_stall;
    // Timestep is complete when the final write-back fires with nothing behind it.
    assign drain_exit = (state_q == DRAIN) && wb_fire && !pend;

    assign tag_in.valid = issue;
    assign tag_in.unit  = LSTM_UNIT_W'(unit_q);

    lstm_shadow_pipe #(.STAGES(STAGES)) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (!bus.pipe_stall),
        .flush_i (bus.abort),
        .tag_i   (tag_in),
        .tag_o   (tag_out),
        .pend_o  (pend)
    );

    // Next-state and counter update; abort overrides everything.
    always_comb begin
        state_d = state_q;
        unit_d  = unit_q;
        t_d     = t_q;
        len_d   = len_q;
        bank_d  = bank_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = len_clamp;
                    t_d     = '0;
                    bank_d  = 1'b0;
                    unit_d  = '0;
                    state_d = (len_clamp == '0) ? DONE : WAIT_X;
                end
            end
            WAIT_X: begin
                if (bus.x_valid) begin
                    unit_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (last_unit) begin
                        unit_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        unit_d = unit_q + UW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_exit) begin
                    bank_d = ~bank_q;
                    if (LW'(t_q) + LW'(1) == len_q) begin
                        t_d     = '0;
                        state_d = DONE;
                    end else begin
                        t_d     = t_q + TW'(1);
                        state_d = WAIT_X;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.abort) begin
            state_d = IDLE;
            unit_d  = '0;
            t_d     = '0;
            bank_d  = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            unit_q  <= '0;
            t_q     <= '0;
            len_q   <= '0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            t_q     <= t_d;
            len_q   <= len_d;
            bank_q  <= bank_d;
        end
    end

    assign bus.iss_valid = issue;
    assign bus.iss_unit  = issue ? unit_q : '0;
    assign bus.iss_first = issue && (t_q == '0);
    assign bus.x_ack     = issue && last_unit;
    assign bus.rd_bank   = bank_q;
    assign bus.wb_valid  = wb_fire;
    assign bus.wb_unit   = wb_fire ? UW'(tag_out.unit) : '0;
    assign bus.t_idx     = t_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule
